// File: rtl/icache_boot_loader.sv
// Boot loader that receives a framed program image over a byte stream and writes it into the icache.
// It holds the CPU core until the image checksum verifies.
module icache_boot_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic              in_byte_valid,
  input  logic [7:0]        in_byte_data,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [31:0]       out_wr_data,
  output logic              out_cpu_hold,
  output logic              out_done,
  output logic              out_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    WAIT_HDR,
    GET_CNT,
    GET_DATA,
    GET_CSUM,
    DONE,
    ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tcnt;
  logic [8:0]      n_words;
  logic [8:0]      wcnt;
  logic [1:0]      idx;
  logic [23:0]     word;
  logic [7:0]      csum;
  logic            in_frame;
  logic            tout;
  logic            last_byte;

  assign in_frame  = (state == GET_CNT) || (state == GET_DATA) || (state == GET_CSUM);
  assign tout      = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign last_byte = (idx == 2'd3) && ((wcnt + 9'd1) == n_words);

  assign out_done     = (state == DONE);
  assign out_err      = (state == ERROR);
  assign out_cpu_hold = (state != DONE);

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= WAIT_HDR;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_start) begin
      state_nxt = WAIT_HDR;
    end else begin
      case (state)
        WAIT_HDR: if (in_byte_valid && in_byte_data == HDR_BYTE) state_nxt = GET_CNT;
        GET_CNT: begin
          if (in_byte_valid) state_nxt = GET_DATA;
          else if (tout)     state_nxt = ERROR;
        end
        GET_DATA: begin
          if (in_byte_valid) begin
            if (last_byte) state_nxt = GET_CSUM;
          end else if (tout) begin
            state_nxt = ERROR;
          end
        end
        GET_CSUM: begin
          if (in_byte_valid) state_nxt = (in_byte_data == csum) ? DONE : ERROR;
          else if (tout)     state_nxt = ERROR;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Write address doubles as the word counter into RAM; it advances on the
  // cycle the write strobe is high, so it wraps to 0 after word 255.
  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      tcnt        <= '0;
      n_words     <= '0;
      wcnt        <= '0;
      idx         <= '0;
      word        <= '0;
      csum        <= '0;
    end else begin
      out_wr_en <= 1'b0;
      if (in_start) begin
        out_wr_addr <= '0;
        tcnt        <= '0;
      end else begin
        if (!in_frame || in_byte_valid) tcnt <= '0;
        else                            tcnt <= tcnt + TW'(1);

        if (out_wr_en) out_wr_addr <= out_wr_addr + ADDR_W'(1);

        if (in_byte_valid) begin
          case (state)
            GET_CNT: begin
              n_words     <= {(in_byte_data == 8'd0), in_byte_data};
              out_wr_addr <= '0;
              csum        <= '0;
              idx         <= '0;
              wcnt        <= '0;
            end
            GET_DATA: begin
              word <= {word[15:0], in_byte_data};
              csum <= csum ^ in_byte_data;
              idx  <= idx + 2'd1;
              if (idx == 2'd3) begin
                out_wr_en   <= 1'b1;
                out_wr_data <= {word, in_byte_data};
                wcnt        <= wcnt + 9'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_boot_loader.sv
// Directed bench for icache_boot_loader: frames are driven byte by byte and expected
// writes are queued, then a write monitor checks them against the icache port.
`timescale 1ns/1ps
module tb_icache_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bv;
  logic [7:0]  bdata;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          wr_base;
  logic [39:0] sb[$];
  logic [31:0] fw[$];

  icache_boot_loader #(.ADDR_W(8), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .in_rst_n      (rst_n),
    .in_start      (start),
    .in_byte_valid (bv),
    .in_byte_data  (bdata),
    .out_wr_en     (wr_en),
    .out_wr_addr   (wr_addr),
    .out_wr_data   (wr_data),
    .out_cpu_hold  (cpu_hold),
    .out_done      (done),
    .out_err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en !== 1'b0) begin
      wr_cnt++;
      if (sb.size() == 0) check("wr_unexpected", {63'd0, wr_en}, 64'd0);
      else                check("wr_addr_data", {24'd0, wr_addr, wr_data}, {24'd0, sb.pop_front()});
    end
  end

  // Called at a falling edge; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    bv    = 1'b1;
    bdata = b;
    @(negedge clk);
    bv    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic bad, input logic [7:0] bad_val);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'h00;
    send(8'hA5);
    send(8'(fw.size()));
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      sb.push_back({8'(i), w});
      for (int j = 3; j >= 0; j--) begin
        cs = cs ^ w[j*8 +: 8];
        send(w[j*8 +: 8]);
      end
    end
    send(bad ? bad_val : cs);
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, {63'd0, done}, {63'd0, d});
    check({tag, "_err"},  {63'd0, err},  {63'd0, e});
    check({tag, "_hold"}, {63'd0, cpu_hold}, {63'd0, h});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bv = 1'b0; bdata = 8'h00;
    #1;
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_addr", {56'd0, wr_addr}, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word frame
    wr_base = wr_cnt;
    fw = '{32'h8C900000, 32'h00002020};
    send_frame(1'b0, 8'h00);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    check("t1_wr_count", 64'(wr_cnt - wr_base), 64'd2);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Pre-header noise ignored; bytes after DONE ignored
    pulse_start();
    check_status("t2_start", 1'b0, 1'b0, 1'b1);
    send(8'h11); send(8'h22);
    wr_base = wr_cnt;
    fw = '{32'hDEADBEEF};
    send_frame(1'b0, 8'h00);
    check_status("t2", 1'b1, 1'b0, 1'b0);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    @(negedge clk);
    check("t2_after_done_writes", 64'(wr_cnt - wr_base), 64'd1);
    check("t2_still_done", {63'd0, done}, 64'd1);

    // Bad checksum
    pulse_start();
    fw = '{32'hDEADBEEF};
    send_frame(1'b1, 8'h00);
    check_status("t3", 1'b0, 1'b1, 1'b1);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    pulse_start();
    check_status("t3_restart", 1'b0, 1'b0, 1'b1);

    // Inter-byte timeout
    wr_base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'hDE);
    repeat (8) @(negedge clk);
    check("t4_err_early", {63'd0, err}, 64'd0);
    repeat (20) @(negedge clk);
    check_status("t4", 1'b0, 1'b1, 1'b1);
    check("t4_no_write", 64'(wr_cnt - wr_base), 64'd0);
    pulse_start();

    // Start coinciding with a header byte: start wins, byte discarded
    wr_base = wr_cnt;
    start = 1'b1; bv = 1'b1; bdata = 8'hA5;
    @(negedge clk);
    start = 1'b0; bv = 1'b0;
    send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h22);
    @(negedge clk);
    check("t7_no_write", 64'(wr_cnt - wr_base), 64'd0);
    check("t7_not_done", {63'd0, done}, 64'd0);
    fw = '{32'h0BADF00D};
    send_frame(1'b0, 8'h00);
    check("t7_done", {63'd0, done}, 64'd1);

    // Full 256-word image, address wraps
    pulse_start();
    wr_base = wr_cnt;
    fw.delete();
    for (int k = 0; k < 256; k++) fw.push_back(32'(k));
    send_frame(1'b0, 8'h00);
    check_status("t5", 1'b1, 1'b0, 1'b0);
    check("t5_wr_count", 64'(wr_cnt - wr_base), 64'd256);
    check("t5_addr_wrap", {56'd0, wr_addr}, 64'd0);
    check("t5_last_data", {32'd0, wr_data}, 64'h0000_00FF);

    // Async reset mid-frame
    pulse_start();
    sb.push_back({8'd0, 32'h11223344});
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    check("t6_pre_addr", {56'd0, wr_addr}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("t6_rst_addr", {56'd0, wr_addr}, 64'd0);
    check("t6_rst_data", {32'd0, wr_data}, 64'd0);
    check_status("t6_rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fw = '{32'hCAFEF00D, 32'h01234567};
    send_frame(1'b0, 8'h00);
    check_status("t6", 1'b1, 1'b0, 1'b0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
